// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the scalar register file write port: scalar writeback always wins, vector results
// wait in a small FIFO and drain on idle cycles. Define WB_ARB_STATS_EN for statistics counters.
`ifndef REGFILE_BITS
`define REGFILE_BITS 5
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module regfile_wb_arbiter #(
  parameter int unsigned VQ_DEPTH     = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     s_wr_en,
  input  logic [`REGFILE_BITS-1:0] s_dest,
  input  logic [`WORD_WIDTH-1:0]   s_data,
  input  logic                     v_valid,
  output logic                     v_ready,
  input  logic [`REGFILE_BITS-1:0] v_dest,
  input  logic [`WORD_WIDTH-1:0]   v_data,
  output logic                     wr_en,
  output logic [`REGFILE_BITS-1:0] dest_addr,
  output logic [`WORD_WIDTH-1:0]   wr_data,
  input  logic [`REGFILE_BITS-1:0] src1_addr,
  input  logic [`REGFILE_BITS-1:0] src2_addr,
  output logic                     pend_hit1,
  output logic                     pend_hit2,
  output logic                     stall_req
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]              stat_stall_cycles,
  output logic [15:0]              stat_kills
`endif
);

  localparam int unsigned PtrW  = $clog2(VQ_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned WaitW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(VQ_DEPTH);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(STARVE_LIMIT - 1);

  typedef enum logic [0:0] {StIdle, StForce} state_e;

  state_e                   state_q, state_d;
  logic [WaitW-1:0]         wait_q, wait_d;
  logic [PtrW-1:0]          rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]          count_q;
  logic [VQ_DEPTH-1:0]      vld_q, vld_d;
  logic [`REGFILE_BITS-1:0] dst_q [VQ_DEPTH];
  logic [`WORD_WIDTH-1:0]   dat_q [VQ_DEPTH];

  logic                empty, full, head_vld, head_kill, pop, push, s_kill_en;
  logic [VQ_DEPTH-1:0] kill_vec, hit1_vec, hit2_vec;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CntFull);
  // Slots outside the live window always hold vld=0, so no extra empty qualifier is needed.
  assign head_vld  = vld_q[rd_ptr_q];
  assign pop       = !empty && (!head_vld || !s_wr_en);
  assign push      = v_valid && !full && (v_dest != '0);
  assign s_kill_en = s_wr_en && (s_dest != '0);
  assign head_kill = kill_vec[rd_ptr_q];

  for (genvar g = 0; g < VQ_DEPTH; g++) begin : g_ent
    assign kill_vec[g] = s_kill_en && vld_q[g] && (dst_q[g] == s_dest);
    assign hit1_vec[g] = vld_q[g] && (dst_q[g] == src1_addr);
    assign hit2_vec[g] = vld_q[g] && (dst_q[g] == src2_addr);
  end

  always_comb begin
    vld_d = vld_q & ~kill_vec;
    if (pop) vld_d[rd_ptr_q] = 1'b0;
    // The tail slot is never live while push is allowed, so a same-cycle kill cannot hit it.
    if (push) vld_d[wr_ptr_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (pop || empty) begin
      wait_d = '0;
    end else if (wait_q != WaitLast) begin
      wait_d = wait_q + WaitW'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (head_vld && !pop && !head_kill && (wait_q == WaitLast)) state_d = StForce;
      end
      StForce: begin
        if (pop || head_kill || empty) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= StIdle;
      wait_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      vld_q   <= vld_d;
      count_q <= count_q + CntW'(push) - CntW'(pop);
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dst_q[wr_ptr_q] <= v_dest;
      dat_q[wr_ptr_q] <= v_data;
    end
  end

  always_comb begin
    wr_en     = 1'b0;
    dest_addr = '0;
    wr_data   = '0;
    if (nrst) begin
      if (s_wr_en) begin
        wr_en     = (s_dest != '0);
        dest_addr = s_dest;
        wr_data   = s_data;
      end else if (head_vld) begin
        wr_en     = 1'b1;
        dest_addr = dst_q[rd_ptr_q];
        wr_data   = dat_q[rd_ptr_q];
      end
    end
  end

  assign v_ready   = nrst && !full;
  assign pend_hit1 = nrst && (src1_addr != '0) && (|hit1_vec);
  assign pend_hit2 = nrst && (src2_addr != '0) && (|hit2_vec);
  assign stall_req = nrst && (state_q == StForce);

`ifdef WB_ARB_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] kill_cnt_q;
  logic [16:0] kill_sum;

  assign kill_sum = {1'b0, kill_cnt_q} + 17'($countones(kill_vec));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      if (stall_req && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      kill_cnt_q <= kill_sum[16] ? '1 : kill_sum[15:0];
    end
  end

  assign stat_stall_cycles = nrst ? stall_cnt_q : '0;
  assign stat_kills        = nrst ? kill_cnt_q : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand-written starvation and wrap
// sequences, then random traffic compared against a queue-based reference model.
`ifndef REGFILE_BITS
`define REGFILE_BITS 5
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module tb_regfile_wb_arbiter;
  localparam int Depth = 4;
  localparam int Limit = 8;
  localparam int RB    = `REGFILE_BITS;
  localparam int WW    = `WORD_WIDTH;
  localparam int NVec  = 17;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          s_wr_en = 1'b0;
  logic [RB-1:0] s_dest = '0;
  logic [WW-1:0] s_data = '0;
  logic          v_valid = 1'b0;
  logic [RB-1:0] v_dest = '0;
  logic [WW-1:0] v_data = '0;
  logic [RB-1:0] src1_addr = '0;
  logic [RB-1:0] src2_addr = '0;
  logic          v_ready, wr_en, pend_hit1, pend_hit2, stall_req;
  logic [RB-1:0] dest_addr;
  logic [WW-1:0] wr_data;
`ifdef WB_ARB_STATS_EN
  logic [31:0]   stat_stall_cycles;
  logic [15:0]   stat_kills;
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .VQ_DEPTH    (Depth),
    .STARVE_LIMIT(Limit)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .s_wr_en  (s_wr_en),
    .s_dest   (s_dest),
    .s_data   (s_data),
    .v_valid  (v_valid),
    .v_ready  (v_ready),
    .v_dest   (v_dest),
    .v_data   (v_data),
    .wr_en    (wr_en),
    .dest_addr(dest_addr),
    .wr_data  (wr_data),
    .src1_addr(src1_addr),
    .src2_addr(src2_addr),
    .pend_hit1(pend_hit1),
    .pend_hit2(pend_hit2),
    .stall_req(stall_req)
`ifdef WB_ARB_STATS_EN
    ,
    .stat_stall_cycles(stat_stall_cycles),
    .stat_kills       (stat_kills)
`endif
  );

  typedef struct packed {
    logic          rdy;
    logic          wr;
    logic [RB-1:0] da;
    logic [WW-1:0] wd;
    logic          p1;
    logic          p2;
    logic          st;
  } out_t;

  // ctl = {nrst, s_wr_en, v_valid}; ef = {v_ready, wr_en, pend_hit1, pend_hit2, stall_req}
  typedef struct {
    logic [2:0]    ctl;
    logic [RB-1:0] sd;
    logic [WW-1:0] sdat;
    logic [RB-1:0] vd;
    logic [WW-1:0] vdat;
    logic [RB-1:0] s1;
    logic [RB-1:0] s2;
    logic [4:0]    ef;
    logic [RB-1:0] eda;
    logic [WW-1:0] ewd;
  } vec_t;

  typedef struct {
    logic          v;
    logic [RB-1:0] d;
    logic [WW-1:0] x;
  } ent_t;

  int   n_pass = 0;
  int   n_total = 0;
  vec_t tbl [NVec];

  // Reference model: in-order list of queued results plus blocked-cycle count and stall flag.
  ent_t mq[$];
  int   m_wait = 0;
  logic m_force = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic cmp_out(input string tag, input out_t a, input out_t e);
    chk($sformatf("%s.v_ready", tag), 32'(a.rdy), 32'(e.rdy));
    chk($sformatf("%s.wr_en", tag), 32'(a.wr), 32'(e.wr));
    chk($sformatf("%s.dest_addr", tag), 32'(a.da), 32'(e.da));
    chk($sformatf("%s.wr_data", tag), 32'(a.wd), 32'(e.wd));
    chk($sformatf("%s.pend_hit1", tag), 32'(a.p1), 32'(e.p1));
    chk($sformatf("%s.pend_hit2", tag), 32'(a.p2), 32'(e.p2));
    chk($sformatf("%s.stall_req", tag), 32'(a.st), 32'(e.st));
  endtask

  function automatic out_t sample();
    out_t o;
    o.rdy = v_ready;
    o.wr  = wr_en;
    o.da  = dest_addr;
    o.wd  = wr_data;
    o.p1  = pend_hit1;
    o.p2  = pend_hit2;
    o.st  = stall_req;
    return o;
  endfunction

  function automatic out_t model_out();
    out_t o;
    o = '0;
    if (nrst) begin
      o.rdy = (mq.size() < Depth);
      if (s_wr_en) begin
        o.wr = (s_dest != 0);
        o.da = s_dest;
        o.wd = s_data;
      end else if (mq.size() > 0 && mq[0].v) begin
        o.wr = 1'b1;
        o.da = mq[0].d;
        o.wd = mq[0].x;
      end
      foreach (mq[i]) begin
        if (mq[i].v && src1_addr != 0 && mq[i].d == src1_addr) o.p1 = 1'b1;
        if (mq[i].v && src2_addr != 0 && mq[i].d == src2_addr) o.p2 = 1'b1;
      end
      o.st = m_force;
    end
    return o;
  endfunction

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    int   sz;
    logic popped, blocked, hkill;
    if (!nrst) begin
      mq.delete();
      m_wait  = 0;
      m_force = 1'b0;
      return;
    end
    sz      = mq.size();
    popped  = (sz > 0) && (!mq[0].v || !s_wr_en);
    blocked = (sz > 0) && mq[0].v && s_wr_en;
    hkill   = blocked && (s_dest != 0) && (mq[0].d == s_dest);
    if (m_force) m_force = !(popped || hkill || sz == 0);
    else m_force = blocked && !hkill && (m_wait >= Limit - 1);
    if (popped || sz == 0) m_wait = 0;
    else if (m_wait < Limit - 1) m_wait++;
    if (s_wr_en && s_dest != 0) begin
      foreach (mq[i]) if (mq[i].d == s_dest) mq[i].v = 1'b0;
    end
    if (popped) void'(mq.pop_front());
    if (v_valid && sz < Depth && v_dest != 0) mq.push_back('{1'b1, v_dest, v_data});
  endtask

  task automatic drive(input logic sw, input logic [RB-1:0] sd, input logic [WW-1:0] sdat,
                       input logic vv, input logic [RB-1:0] vd, input logic [WW-1:0] vdat,
                       input logic [RB-1:0] s1, input logic [RB-1:0] s2);
    @(negedge clk);
    nrst      = 1'b1;
    s_wr_en   = sw;
    s_dest    = sd;
    s_data    = sdat;
    v_valid   = vv;
    v_dest    = vd;
    v_data    = vdat;
    src1_addr = s1;
    src2_addr = s2;
    #2;
  endtask

  function automatic vec_t mk(input logic [2:0] ctl, input logic [RB-1:0] sd,
                              input logic [WW-1:0] sdat, input logic [RB-1:0] vd,
                              input logic [WW-1:0] vdat, input logic [RB-1:0] s1,
                              input logic [RB-1:0] s2, input logic [4:0] ef,
                              input logic [RB-1:0] eda, input logic [WW-1:0] ewd);
    vec_t v;
    v.ctl = ctl; v.sd = sd; v.sdat = sdat; v.vd = vd; v.vdat = vdat;
    v.s1 = s1; v.s2 = s2; v.ef = ef; v.eda = eda; v.ewd = ewd;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    out_t exp_o;
    int   sw_pct = 40;

    //           ctl     sd     sdat          vd      vdat          s1     s2     ef        eda    ewd
    tbl[0]  = mk(3'b000, 5'd0, 32'h0,        5'd0,  32'h0,        5'd0,  5'd0,  5'b00000, 5'd0, 32'h0);
    tbl[1]  = mk(3'b000, 5'd0, 32'h0,        5'd0,  32'h0,        5'd5,  5'd0,  5'b00000, 5'd0, 32'h0);
    tbl[2]  = mk(3'b101, 5'd0, 32'h0,        5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  5'b10000, 5'd0, 32'h0);
    tbl[3]  = mk(3'b100, 5'd0, 32'h0,        5'd0,  32'h0,        5'd5,  5'd0,  5'b11100, 5'd5, 32'hDEADBEEF);
    tbl[4]  = mk(3'b100, 5'd0, 32'h0,        5'd0,  32'h0,        5'd5,  5'd0,  5'b10000, 5'd0, 32'h0);
    tbl[5]  = mk(3'b111, 5'd3, 32'h33,       5'd7,  32'h11,       5'd7,  5'd3,  5'b11000, 5'd3, 32'h33);
    tbl[6]  = mk(3'b110, 5'd7, 32'h22,       5'd0,  32'h0,        5'd7,  5'd0,  5'b11100, 5'd7, 32'h22);
    tbl[7]  = mk(3'b100, 5'd0, 32'h0,        5'd0,  32'h0,        5'd7,  5'd0,  5'b10000, 5'd0, 32'h0);
    tbl[8]  = mk(3'b100, 5'd0, 32'h0,        5'd0,  32'h0,        5'd7,  5'd0,  5'b10000, 5'd0, 32'h0);
    tbl[9]  = mk(3'b101, 5'd0, 32'h0,        5'd0,  32'hFF,       5'd0,  5'd0,  5'b10000, 5'd0, 32'h0);
    tbl[10] = mk(3'b100, 5'd0, 32'h0,        5'd0,  32'h0,        5'd0,  5'd0,  5'b10000, 5'd0, 32'h0);
    tbl[11] = mk(3'b111, 5'd1, 32'h1,        5'd10, 32'hA0,       5'd0,  5'd0,  5'b11000, 5'd1, 32'h1);
    tbl[12] = mk(3'b111, 5'd1, 32'h2,        5'd11, 32'hA1,       5'd10, 5'd0,  5'b11100, 5'd1, 32'h2);
    tbl[13] = mk(3'b111, 5'd1, 32'h3,        5'd12, 32'hA2,       5'd12, 5'd11, 5'b11010, 5'd1, 32'h3);
    tbl[14] = mk(3'b010, 5'd1, 32'h4,        5'd0,  32'h0,        5'd10, 5'd0,  5'b00000, 5'd0, 32'h0);
    tbl[15] = mk(3'b100, 5'd0, 32'h0,        5'd0,  32'h0,        5'd10, 5'd11, 5'b10000, 5'd0, 32'h0);
    tbl[16] = mk(3'b100, 5'd0, 32'h0,        5'd0,  32'h0,        5'd12, 5'd0,  5'b10000, 5'd0, 32'h0);

    for (int i = 0; i < NVec; i++) begin
      @(negedge clk);
      {nrst, s_wr_en, v_valid} = tbl[i].ctl;
      s_dest    = tbl[i].sd;
      s_data    = tbl[i].sdat;
      v_dest    = tbl[i].vd;
      v_data    = tbl[i].vdat;
      src1_addr = tbl[i].s1;
      src2_addr = tbl[i].s2;
      #2;
      exp_o.rdy = tbl[i].ef[4];
      exp_o.wr  = tbl[i].ef[3];
      exp_o.p1  = tbl[i].ef[2];
      exp_o.p2  = tbl[i].ef[1];
      exp_o.st  = tbl[i].ef[0];
      exp_o.da  = tbl[i].eda;
      exp_o.wd  = tbl[i].ewd;
      cmp_out($sformatf("vec%0d", i), sample(), exp_o);
      model_step();
    end

    // Starvation: one queued entry held off by scalar writes for ten cycles.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 5'd0, 5'd0);
    chk("starve0.stall_req", 32'(stall_req), 32'd0);
    model_step();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 5'd2, 32'h2000 + k, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
      chk($sformatf("starve%0d.stall_req", k), 32'(stall_req), (k >= 9) ? 32'd1 : 32'd0);
      chk($sformatf("starve%0d.pend_hit1", k), 32'(pend_hit1), 32'd1);
      model_step();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    chk("starve_drain.wr_en", 32'(wr_en), 32'd1);
    chk("starve_drain.dest_addr", 32'(dest_addr), 32'd9);
    chk("starve_drain.wr_data", 32'(wr_data), 32'h99);
    chk("starve_drain.stall_req", 32'(stall_req), 32'd1);
    model_step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    chk("starve_after.stall_req", 32'(stall_req), 32'd0);
    chk("starve_after.wr_en", 32'(wr_en), 32'd0);
    chk("starve_after.pend_hit1", 32'(pend_hit1), 32'd0);
    model_step();

    // Fill to capacity under scalar traffic, then drain while refilling across the wrap.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd2, 32'h3000, 1'b1, RB'(16 + i), 32'h100 + i, 5'd0, 5'd0);
      chk($sformatf("fill%0d.v_ready", i), 32'(v_ready), (i < 4) ? 32'd1 : 32'd0);
      model_step();
    end
    begin
      int   cnt = 4;
      int   nv = 4;
      int   nw = 0;
      int   cyc = 0;
      logic popd, acc;
      while (nw < 10 && cyc < 30) begin
        drive(1'b0, 5'd0, 32'h0, nv < 10, RB'(16 + nv), 32'h100 + nv, 5'd0, 5'd0);
        chk($sformatf("wrap%0d.v_ready", cyc), 32'(v_ready), (cnt < Depth) ? 32'd1 : 32'd0);
        popd = (cnt > 0);
        acc  = (nv < 10) && (cnt < Depth);
        if (popd) begin
          chk($sformatf("wrap%0d.wr_en", cyc), 32'(wr_en), 32'd1);
          chk($sformatf("wrap%0d.dest_addr", cyc), 32'(dest_addr), 32'(16 + nw));
          chk($sformatf("wrap%0d.wr_data", cyc), 32'(wr_data), 32'(32'h100 + nw));
          nw++;
        end
        if (acc) nv++;
        cnt = cnt - int'(popd) + int'(acc);
        model_step();
        cyc++;
      end
      chk("wrap.entries_written", 32'(nw), 32'd10);
    end

    // Random traffic against the model; small address range forces kills and hazard hits.
    for (int c = 0; c < 800; c++) begin
      if (c % 64 == 0) sw_pct = (c % 128 == 0) ? 92 : 40;
      @(negedge clk);
      nrst      = (c == 0) ? 1'b0 : ($urandom_range(99) >= 2);
      s_wr_en   = ($urandom_range(99) < sw_pct);
      s_dest    = RB'($urandom_range(7));
      s_data    = $urandom();
      v_valid   = ($urandom_range(99) < 60);
      v_dest    = RB'($urandom_range(7));
      v_data    = $urandom();
      src1_addr = RB'($urandom_range(7));
      src2_addr = RB'($urandom_range(7));
      #2;
      cmp_out($sformatf("rnd%0d", c), sample(), model_out());
      model_step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the scalar register file's single write port between two requesters.
  - Scalar pipeline writeback: highest priority, never stalled by this block.
  - Vector coprocessor scalar-result return path (vmv.x.s, vcpop, etc.).
- Vector results are queued in a small FIFO and drained on cycles when scalar writeback is idle.
- Provides hazard flags for queued destinations and a starvation-driven pipeline stall request.
- Sits between the WB stage / vector coprocessor and the register file write port (wr_en, dest_addr, wr_data).

Parameters:
- VQ_DEPTH, 4: vector result queue entries; power of two, minimum 2.
- STARVE_LIMIT, 8: cycles a valid queue head may wait before stall_req is raised; minimum 1.

Ports:
- clk  in  1  system clock
- nrst  in  1  reset, synchronous, active-low
- s_wr_en  in  1  scalar writeback request
- s_dest  in  `REGFILE_BITS  scalar destination
- s_data  in  `WORD_WIDTH  scalar write data
- v_valid  in  1  vector result valid
- v_ready  out  1  queue can accept
- v_dest  in  `REGFILE_BITS  vector result destination
- v_data  in  `WORD_WIDTH  vector result data
- wr_en  out  1  to regfile
- dest_addr  out  `REGFILE_BITS  to regfile
- wr_data  out  `WORD_WIDTH  to regfile
- src1_addr  in  `REGFILE_BITS  decode-stage source 1
- src2_addr  in  `REGFILE_BITS  decode-stage source 2
- pend_hit1  out  1  src1 matches a valid queued entry
- pend_hit2  out  1  src2 matches a valid queued entry
- stall_req  out  1  request pipeline writeback freeze

Behaviour:
- Clocking and reset
  - One clock (clk). Reset is synchronous and active-low (nrst): sampled only at posedge clk.
  - Reset flushes the queue, clears the wait counter, and sets state IDLE.
  - While nrst=0, all outputs are driven 0, including mid-drain; in-flight vector results are discarded.
- Enqueue
  - v_valid && v_ready at a posedge pushes {valid=1, dest, data}.
  - v_ready = !full, from registered count only; no enqueue-while-full even when dequeuing the same cycle.
  - Results with v_dest=0 are accepted but not stored (count unchanged).
- Write port mux (combinational)
  - If s_wr_en: wr_en=(s_dest!=0), dest_addr=s_dest, wr_data=s_data.
  - Else if the queue head is valid: drive head; pop at the posedge.
  - Else wr_en=0, dest_addr=0, wr_data=0.
  - Minimum vector latency: accepted at edge N, written at edge N+1.
- Killed entries
  - A head whose valid=0 is popped silently in one cycle with no write, regardless of s_wr_en.
- WAW kill
  - When s_wr_en && s_dest!=0, every queued entry with dest==s_dest has valid cleared at that edge; the scalar write is younger.
  - An entry being enqueued in the same cycle is not killed.
- Hazard flags (combinational)
  - pend_hitN=1 iff srcN_addr!=0 and any valid entry has dest==srcN_addr.
- FSM and wait counter
  - States: IDLE, FORCE.
  - wait_cnt increments each cycle the head is valid and not popped; it clears on a pop or when the queue is empty.
  - IDLE -> FORCE when wait_cnt reaches STARVE_LIMIT-1 and the head is still blocked.
  - stall_req is registered: 1 throughout FORCE.
  - In FORCE, scalar still wins if s_wr_en=1 (the pipeline freezes one cycle late).
  - FORCE -> IDLE on the edge where the head pops or is killed.
- Pointer arithmetic
  - Pointers are log2(VQ_DEPTH) bits and wrap modulo VQ_DEPTH.
  - count is log2(VQ_DEPTH)+1 bits; full = (count==VQ_DEPTH).

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- Defined: adds outputs stat_stall_cycles (32 bits, counts cycles with stall_req=1) and stat_kills (16 bits, counts entries invalidated by WAW kill).
  - Both counters saturate and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset with queue holding 3 entries, nrst=0 one cycle -> v_ready=0 during reset; after release, no wr_en from the old entries, v_ready=1, stall_req=0.
- Vector x5=0xDEADBEEF accepted at edge N, s_wr_en=0 -> wr_en=1, dest_addr=5, wr_data=0xDEADBEEF before edge N+1; pend_hit1=1 for src1_addr=5 until that edge.
- Queue x7=0x11, then scalar writes x7=0x22 -> entry killed; later cycles show no write to x7; pend_hit for x7 drops after the scalar edge.
- s_wr_en held 1 for 10 cycles with one queued entry (STARVE_LIMIT=8) -> stall_req rises after 8 blocked cycles; s_wr_en=0 -> entry written, stall_req=0 next cycle.
- Fill queue with 4 entries (VQ_DEPTH=4) while s_wr_en=1 -> v_ready=0; one pop frees a slot, v_ready=1 the next cycle; wrap-around order preserved over 10 entries.
- Enqueue v_dest=0 with data 0xFF -> accepted, no regfile write, count unchanged.
